load_scoreboard: RTL

Decode-stage hazard unit that handles the hazards operand forwarding cannot resolve. It tracks loads that are issued but whose memory data is not yet forwardable, and stalls any dependent instruction in ID until the data arrives. It also limits the number of loads in flight. It sits beside the ID/EX register, and its stall output gates PC and IF/ID writes and injects a bubble into ID/EX.

---
 rtl/load_scoreboard_pkg.sv | 16 +
 rtl/load_scoreboard_if.sv | 33 +++
 rtl/load_scoreboard_counter.sv | 37 +++
 rtl/load_scoreboard.sv | 73 +++++++
 4 files changed

// File: rtl/load_scoreboard_pkg.sv
// Shared constants for the load scoreboard: register-index width, the zero
// register, the default load limit and the derived counter width.
package load_scoreboard_pkg;

  localparam int unsigned REG_W         = 5;
  localparam logic [4:0]  REG_ZERO      = 5'd0;
  localparam int unsigned DEF_MAX_LOADS = 2;

  // Smallest width whose range exceeds n.
  function automatic int unsigned cw_for(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned DEF_CW = cw_for(DEF_MAX_LOADS);

endpackage

// File: rtl/load_scoreboard_if.sv
// ID-stage and memory-return signals seen by the load scoreboard.
interface load_scoreboard_if
  import load_scoreboard_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
);
  logic             idValid;
  logic [REG_W-1:0] idRs;
  logic [REG_W-1:0] idRt;
  logic             idUsesRs;
  logic             idUsesRt;
  logic             idMemRead;
  logic [REG_W-1:0] idRd;
  logic             loadDone;
  logic [REG_W-1:0] loadDoneRd;
  logic             killValid;
  logic [REG_W-1:0] killRd;
  logic             stall;
  logic [CW-1:0]    loadsInFlight;
  logic             err;

  modport master (
    output idValid, idRs, idRt, idUsesRs, idUsesRt, idMemRead, idRd,
           loadDone, loadDoneRd, killValid, killRd,
    input  stall, loadsInFlight, err
  );

  modport slave (
    input  idValid, idRs, idRt, idUsesRs, idUsesRt, idMemRead, idRd,
           loadDone, loadDoneRd, killValid, killRd,
    output stall, loadsInFlight, err
  );
endinterface

// File: rtl/load_scoreboard_counter.sv
// Inc/dec counter that saturates at zero; a decrement at zero is dropped
// and reported on underflow_c.
module load_scoreboard_counter #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec_a,
  input  logic          dec_b,
  output logic [CW-1:0] count,
  output logic          underflow_c
);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] after_a, after_b;
  logic          uf_a, uf_b;

  // Decrements are judged against the pre-increment value so a return for
  // a load that was never issued is always caught.
  always_comb begin
    uf_a        = dec_a && (count_q == '0);
    after_a     = count_q - CW'(dec_a && !uf_a);
    uf_b        = dec_b && (after_a == '0);
    after_b     = after_a - CW'(dec_b && !uf_b);
    underflow_c = uf_a || uf_b;
    count_d     = after_b + CW'(inc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/load_scoreboard.sv
// Load-use hazard unit: per-register outstanding-load counts, a global load
// limit, the ID stall and a sticky protocol-error flag.
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int unsigned MAX_LOADS = DEF_MAX_LOADS,
  parameter int unsigned CW        = cw_for(MAX_LOADS)
) (
  input  logic           clk,
  input  logic           rst,
  load_scoreboard_if.slave sb
);

  localparam int unsigned NREG = 32;

  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] reg_uf;
  logic [CW-1:0]   tot;
  logic            tot_uf;
  logic [CW-1:0]   eff_a, eff_b, tot_eff;
  logic            dep_a, dep_b, full, stall_c, issue;
  logic            err_q, err_d;

  // A load returning this cycle is forwardable in the consumer's EX, so it
  // no longer counts against the consumer.
  always_comb begin
    eff_a   = cnt[sb.idRs]
              - CW'(sb.loadDone  && (sb.loadDoneRd == sb.idRs))
              - CW'(sb.killValid && (sb.killRd     == sb.idRs));
    eff_b   = cnt[sb.idRt]
              - CW'(sb.loadDone  && (sb.loadDoneRd == sb.idRt))
              - CW'(sb.killValid && (sb.killRd     == sb.idRt));
    tot_eff = tot - CW'(sb.loadDone) - CW'(sb.killValid);
    dep_a   = sb.idUsesRs && (sb.idRs != REG_ZERO) && (eff_a != '0);
    dep_b   = sb.idUsesRt && (sb.idRt != REG_ZERO) && (eff_b != '0);
    full    = sb.idMemRead && (tot_eff == CW'(MAX_LOADS));
    stall_c = rst && sb.idValid && (dep_a || dep_b || full);
    issue   = sb.idValid && !stall_c && sb.idMemRead && (sb.idRd != REG_ZERO);
    err_d   = err_q || (|reg_uf) || tot_uf;
  end

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    load_scoreboard_counter #(.CW(CW)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc         (issue        && (sb.idRd       == REG_W'(r))),
      .dec_a       (sb.loadDone  && (sb.loadDoneRd == REG_W'(r))),
      .dec_b       (sb.killValid && (sb.killRd     == REG_W'(r))),
      .count       (cnt[r]),
      .underflow_c (reg_uf[r])
    );
  end

  load_scoreboard_counter #(.CW(CW)) u_tot (
    .clk         (clk),
    .rst         (rst),
    .inc         (issue),
    .dec_a       (sb.loadDone),
    .dec_b       (sb.killValid),
    .count       (tot),
    .underflow_c (tot_uf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign sb.stall         = stall_c;
  assign sb.loadsInFlight = tot;
  assign sb.err           = err_q;

endmodule
